// File: rtl/alu_btn_sequencer.sv
// alu_btn_sequencer
//
// Sits between the board buttons/switches and the 8-bit add/sub ALU. Each raw button
// is synchronized and debounced. Simultaneous presses are arbitrated with priority
// store1 > store2 > add > sub. Each accepted command produces exactly one single-cycle
// alu_* pulse. Operand validity is tracked, and a stable operand byte is driven out.
//
// Optional build macro: SEQ_TIMEOUT_EN. When defined, operands that stay idle for
// TIMEOUT_CYCLES are invalidated and a one-cycle timeout pulse is emitted. When it is
// not defined, timeout is tied low.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   btn_store1/2      raw buttons: load operand A / B from sw
//   btn_add/sub       raw buttons: request A+B / A-B
//   sw[7:0]           operand switches
//   alu_store1/2      one-cycle pulse: ALU latches op_data as A / B
//   alu_add/sub       one-cycle pulse: ALU adds / subtracts
//   op_data[7:0]      registered operand presented to the ALU
//   a_vld, b_vld      operand A / B loaded
//   err               sticky: last arithmetic command was rejected
//   busy              sequencer not idle
//   timeout           one-cycle pulse on operand expiry
module alu_btn_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned TIMEOUT_CYCLES  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_store1,
  input  logic       btn_store2,
  input  logic       btn_add,
  input  logic       btn_sub,
  input  logic [7:0] sw,
  output logic       alu_store1,
  output logic       alu_store2,
  output logic       alu_add,
  output logic       alu_sub,
  output logic [7:0] op_data,
  output logic       a_vld,
  output logic       b_vld,
  output logic       err,
  output logic       busy,
  output logic       timeout
);

  if (DEBOUNCE_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be at least 1");
  end

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StIssue   = 2'd1;
  localparam logic [1:0] StRelease = 2'd2;

  // Bit order everywhere: [0] store1, [1] store2, [2] add, [3] sub.
  logic [3:0] btn_raw;
  logic [3:0] sync1_q, sync2_q, db_q, db_prev_q;
  logic [CNT_W-1:0] db_cnt_q [4];
  logic [3:0] press, grant;
  logic [1:0] state_q, state_d;
  logic       accept, expire;

  assign btn_raw = {btn_sub, btn_add, btn_store2, btn_store1};

  // Synchronizer and debouncer. The level flips only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement with the synchronized input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      db_prev_q <= db_q;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign press = db_q & ~db_prev_q;

  // Fixed priority; losing events are simply dropped.
  always_comb begin
    grant = 4'b0000;
    if (press[0])      grant = 4'b0001;
    else if (press[1]) grant = 4'b0010;
    else if (press[2]) grant = 4'b0100;
    else if (press[3]) grant = 4'b1000;
  end

  assign accept = (state_q == StIdle) && (grant != 4'b0000);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (accept) state_d = StIssue;
      StIssue:   state_d = StRelease;
      StRelease: if (db_q == 4'b0000) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  assign busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      alu_store1 <= 1'b0;
      alu_store2 <= 1'b0;
      alu_add    <= 1'b0;
      alu_sub    <= 1'b0;
      op_data    <= 8'h00;
      a_vld      <= 1'b0;
      b_vld      <= 1'b0;
      err        <= 1'b0;
    end else begin
      state_q    <= state_d;
      // Pulses are registered on acceptance, so they are high only during ISSUE.
      alu_store1 <= accept & grant[0];
      alu_store2 <= accept & grant[1];
      alu_add    <= accept & grant[2] & a_vld & b_vld;
      alu_sub    <= accept & grant[3] & a_vld & b_vld;
      if (expire) begin
        a_vld <= 1'b0;
        b_vld <= 1'b0;
      end
      if (accept) begin
        if (grant[0] || grant[1]) begin
          op_data <= sw;
          err     <= 1'b0;
          if (grant[0]) a_vld <= 1'b1;
          if (grant[1]) b_vld <= 1'b1;
        end else begin
          // Arithmetic: rejected (no pulse, err set) unless both operands loaded.
          err <= ~(a_vld & b_vld);
        end
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] idle_cnt_q;
  logic             counting;

  // An accepted event in the expiry cycle suppresses the expiry.
  assign counting = (state_q == StIdle) && (a_vld || b_vld) && !accept;
  assign expire   = counting && (idle_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      timeout    <= 1'b0;
    end else begin
      timeout <= expire;
      if (!counting || expire) idle_cnt_q <= '0;
      else                     idle_cnt_q <= idle_cnt_q + CNT_W'(1);
    end
  end
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule
